// File: rtl/asic_pkg.sv
// Shared types and constants for the ASIC RAM arbiter slice.
package asic_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_SPR  = 2'd2,
    REQ_DMA  = 2'd3
  } asic_req_t;

  localparam logic [15:0] ASIC_WIN_LO = 16'h4000;
  localparam logic [15:0] ASIC_WIN_HI = 16'h7FFF;

  function automatic logic in_asic_window(input logic [15:0] addr);
    return (addr >= ASIC_WIN_LO) && (addr <= ASIC_WIN_HI);
  endfunction

endpackage

// File: rtl/asic_rr_pick.sv
// Per-cycle requester choice: CPU first unless a sprite/DMA request has waited
// MAX_WAIT cycles; sprite and DMA share by round-robin.
module asic_rr_pick
  import asic_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      cpu_pend,
  input  logic      spr_elig,
  input  logic      dma_elig,
  output asic_req_t pick
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] spr_cnt_r;
  logic [CW-1:0] dma_cnt_r;
  logic          rr_dma_r;   // 0: sprite has round-robin priority
  logic          spr_sat_s;
  logic          dma_sat_s;

  assign spr_sat_s = spr_elig && (spr_cnt_r == CNT_MAX);
  assign dma_sat_s = dma_elig && (dma_cnt_r == CNT_MAX);

  // Priority decision: starved sprite/DMA, then CPU, then round-robin.
  always_comb begin
    pick = REQ_NONE;
    if (spr_sat_s && dma_sat_s) begin
      pick = rr_dma_r ? REQ_DMA : REQ_SPR;
    end else if (spr_sat_s) begin
      pick = REQ_SPR;
    end else if (dma_sat_s) begin
      pick = REQ_DMA;
    end else if (cpu_pend) begin
      pick = REQ_CPU;
    end else if (spr_elig && dma_elig) begin
      pick = rr_dma_r ? REQ_DMA : REQ_SPR;
    end else if (spr_elig) begin
      pick = REQ_SPR;
    end else if (dma_elig) begin
      pick = REQ_DMA;
    end else begin
      pick = REQ_NONE;
    end
  end

  // Wait counters and round-robin pointer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      spr_cnt_r <= CNT_ZERO;
      dma_cnt_r <= CNT_ZERO;
      rr_dma_r  <= 1'b0;
    end else begin
      if (!spr_elig || pick == REQ_SPR) begin
        spr_cnt_r <= CNT_ZERO;
      end else if (spr_cnt_r != CNT_MAX) begin
        spr_cnt_r <= spr_cnt_r + CNT_ONE;
      end else begin
        spr_cnt_r <= spr_cnt_r;
      end

      if (!dma_elig || pick == REQ_DMA) begin
        dma_cnt_r <= CNT_ZERO;
      end else if (dma_cnt_r != CNT_MAX) begin
        dma_cnt_r <= dma_cnt_r + CNT_ONE;
      end else begin
        dma_cnt_r <= dma_cnt_r;
      end

      case (pick)
        REQ_SPR: rr_dma_r <= 1'b1;
        REQ_DMA: rr_dma_r <= 1'b0;
        default: rr_dma_r <= rr_dma_r;
      endcase
    end
  end

endmodule

// File: rtl/asic_ram_arbiter.sv
// Shares the single-port ASIC RAM between the CPU window, sprite fetcher and
// sound DMA; one RAM operation per cycle, CPU stalled through cpu_wait.
module asic_ram_arbiter
  import asic_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              asic_valid,
  input  logic              page_en,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_rvalid,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_q
);

  logic              strobe_q_r;
  logic              cpu_pend_r;
  logic [ADDR_W-1:0] cpu_addr_r;
  logic [7:0]        cpu_din_r;
  logic              cpu_is_wr_r;
  asic_req_t         op1_src_r;    // requester owning the RAM op this cycle
  logic              cpu_rd2_r;    // CPU read data on ram_q this cycle
  logic              cpu_wait_s;
  logic              cpu_hit_s;
  logic              spr_elig_s;
  logic              dma_elig_s;
  asic_req_t         pick_s;

  assign cpu_wait_s = cpu_pend_r | (op1_src_r == REQ_CPU) | cpu_rd2_r;
  assign cpu_wait   = cpu_wait_s;

  // Accesses are captured only on a fresh strobe edge into an unlocked, mapped window.
  assign cpu_hit_s = (cpu_rd | cpu_wr) & ~strobe_q_r & ~cpu_wait_s &
                     in_asic_window(cpu_addr) & asic_valid & page_en;

  // A requester is not eligible in the cycle its previous grant is showing.
  assign spr_elig_s = spr_req & ~spr_gnt;
  assign dma_elig_s = dma_req & ~dma_gnt;

  asic_rr_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cpu_pend (cpu_pend_r),
    .spr_elig (spr_elig_s),
    .dma_elig (dma_elig_s),
    .pick     (pick_s)
  );

  // CPU capture, RAM command stage and read-return stage.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q_r  <= 1'b0;
      cpu_pend_r  <= 1'b0;
      cpu_addr_r  <= {ADDR_W{1'b0}};
      cpu_din_r   <= 8'h00;
      cpu_is_wr_r <= 1'b0;
      op1_src_r   <= REQ_NONE;
      cpu_rd2_r   <= 1'b0;
      ram_addr    <= {ADDR_W{1'b0}};
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_din     <= 8'h00;
      spr_gnt     <= 1'b0;
      dma_gnt     <= 1'b0;
      spr_rvalid  <= 1'b0;
      dma_rvalid  <= 1'b0;
      cpu_dout    <= 8'h00;
    end else begin
      strobe_q_r <= cpu_rd | cpu_wr;

      if (cpu_hit_s) begin
        cpu_pend_r  <= 1'b1;
        cpu_addr_r  <= cpu_addr[ADDR_W-1:0];
        cpu_din_r   <= cpu_din;
        cpu_is_wr_r <= cpu_wr;
      end else if (pick_s == REQ_CPU) begin
        cpu_pend_r <= 1'b0;
      end else begin
        cpu_pend_r <= cpu_pend_r;
      end

      case (pick_s)
        REQ_CPU: begin
          ram_addr <= cpu_addr_r;
          ram_rd   <= ~cpu_is_wr_r;
          ram_wr   <= cpu_is_wr_r;
          ram_din  <= cpu_din_r;
          spr_gnt  <= 1'b0;
          dma_gnt  <= 1'b0;
        end
        REQ_SPR: begin
          ram_addr <= spr_addr;
          ram_rd   <= 1'b1;
          ram_wr   <= 1'b0;
          ram_din  <= 8'h00;
          spr_gnt  <= 1'b1;
          dma_gnt  <= 1'b0;
        end
        REQ_DMA: begin
          ram_addr <= dma_addr;
          ram_rd   <= 1'b1;
          ram_wr   <= 1'b0;
          ram_din  <= 8'h00;
          spr_gnt  <= 1'b0;
          dma_gnt  <= 1'b1;
        end
        default: begin
          ram_addr <= ram_addr;
          ram_rd   <= 1'b0;
          ram_wr   <= 1'b0;
          ram_din  <= ram_din;
          spr_gnt  <= 1'b0;
          dma_gnt  <= 1'b0;
        end
      endcase
      op1_src_r <= pick_s;

      spr_rvalid <= (op1_src_r == REQ_SPR);
      dma_rvalid <= (op1_src_r == REQ_DMA);
      cpu_rd2_r  <= (op1_src_r == REQ_CPU) & ram_rd;

      if (cpu_rd2_r) begin
        cpu_dout <= ram_q;
      end else begin
        cpu_dout <= cpu_dout;
      end
    end
  end

  // Shared read data is only driven while some requester's data is on ram_q.
  always_comb begin
    rdata = 8'h00;
    if (spr_rvalid | dma_rvalid | cpu_rd2_r) begin
      rdata = ram_q;
    end else begin
      rdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_asic_ram_arbiter.sv
// Scoreboard bench for asic_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_asic_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        asic_valid = 1'b1;
  logic        page_en = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        spr_req = 1'b0;
  logic [13:0] spr_addr = 14'h0000;
  logic        spr_gnt;
  logic        spr_rvalid;
  logic        dma_req = 1'b0;
  logic [13:0] dma_addr = 14'h0000;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  rdata;
  logic [13:0] ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q = 8'h00;

  always #5 clk_sys = ~clk_sys;

  asic_ram_arbiter #(.ADDR_W(14), .MAX_WAIT(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .asic_valid(asic_valid), .page_en(page_en),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_din(ram_din), .ram_q(ram_q)
  );

  logic [7:0] ram_mem [0:16383];
  logic [7:0] shadow  [0:16383];

  function automatic logic [7:0] preload(input int a);
    return 8'((a * 37 + 11) ^ (a >> 6));
  endfunction

  // RAM model: synchronous write, registered read data.
  always @(posedge clk_sys) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_din;
    if (ram_rd) ram_q <= ram_mem[ram_addr];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [7:0]  spr_q [$];
  logic [7:0]  dma_q [$];
  logic [21:0] wr_q [$];
  int          grant_log [$];
  bit          log_en = 1'b0;
  int          n_wr = 0;
  int          n_dma_rv = 0;
  logic        spr_gnt_d = 1'b0;
  logic        dma_gnt_d = 1'b0;

  // Output monitor: scoreboard pushes on grants, pops on rvalid, checks writes.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (spr_gnt) begin
        check_eq("spr_cmd", {ram_rd, ram_wr, ram_addr}, {1'b1, 1'b0, spr_addr});
        spr_q.push_back(shadow[spr_addr]);
        if (log_en) grant_log.push_back(1);
      end
      if (dma_gnt) begin
        check_eq("dma_cmd", {ram_rd, ram_wr, ram_addr}, {1'b1, 1'b0, dma_addr});
        dma_q.push_back(shadow[dma_addr]);
        if (log_en) grant_log.push_back(2);
      end
      if (spr_rvalid) begin
        check_eq("spr_lat", spr_gnt_d, 1'b1);
        if (spr_q.size() > 0) check_eq("spr_rdata", rdata, spr_q.pop_front());
        else check_eq("spr_unexpected_rvalid", spr_rvalid, 1'b0);
      end
      if (dma_rvalid) begin
        n_dma_rv++;
        check_eq("dma_lat", dma_gnt_d, 1'b1);
        if (dma_q.size() > 0) check_eq("dma_rdata", rdata, dma_q.pop_front());
        else check_eq("dma_unexpected_rvalid", dma_rvalid, 1'b0);
      end
      if (ram_wr) begin
        n_wr++;
        check_eq("wr_only_cpu", spr_gnt | dma_gnt, 1'b0);
        if (wr_q.size() > 0) check_eq("ram_wr", {ram_addr, ram_din}, wr_q.pop_front());
        else check_eq("ram_wr_unexpected", ram_wr, 1'b0);
      end
      spr_gnt_d <= spr_gnt;
      dma_gnt_d <= dma_gnt;
    end else begin
      spr_gnt_d <= 1'b0;
      dma_gnt_d <= 1'b0;
    end
  end

  function automatic logic [63:0] all_outs();
    return {19'd0, cpu_dout, cpu_wait, spr_gnt, spr_rvalid, dma_gnt, dma_rvalid,
            rdata, ram_addr, ram_rd, ram_wr, ram_din};
  endfunction

  // One CPU access: expected wait length is given by the caller, data by the shadow.
  task automatic cpu_op(input logic [15:0] a, input bit rd, input bit wr, input logic [7:0] d,
                        input int exp_wait, input string tag);
    int wc = 0;
    logic [7:0] exp_d;
    exp_d = shadow[a[13:0]];
    @(posedge clk_sys); #1;
    cpu_addr = a; cpu_din = d; cpu_rd = rd; cpu_wr = wr;
    if (exp_wait > 0 && wr) begin
      wr_q.push_back({a[13:0], d});
      shadow[a[13:0]] = d;
    end
    repeat (8) begin
      @(negedge clk_sys);
      if (cpu_wait) wc++;
    end
    check_eq({tag, "_wait"}, wc, exp_wait);
    if (exp_wait > 0 && !wr) check_eq({tag, "_dout"}, cpu_dout, exp_d);
    @(posedge clk_sys); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    spr_req = 1'b0; dma_req = 1'b0;
    #1;
    check_eq({tag, "_outs_zero"}, all_outs(), 64'd0);
    spr_q.delete(); dma_q.delete();
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int wr_before;
    int rv_before;
    int first;
    int cpu_ops;
    bit got;
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i] = preload(i);
      shadow[i]  = preload(i);
    end

    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("reset_outs_zero", all_outs(), 64'd0);
    reset_n = 1'b1;

    // Basic unlocked write then read back.
    cpu_op(16'h4123, 1'b0, 1'b1, 8'h5A, 2, "wr1");
    cpu_op(16'h4123, 1'b1, 1'b0, 8'h00, 3, "rd1");
    check_eq("wr1_count", n_wr, 1);

    // Locked write is dropped; non-hits never stall.
    asic_valid = 1'b0;
    wr_before = n_wr;
    cpu_op(16'h4000, 1'b0, 1'b1, 8'hEE, 0, "locked_wr");
    check_eq("locked_no_ram_wr", n_wr, wr_before);
    asic_valid = 1'b1;
    cpu_op(16'h4000, 1'b1, 1'b0, 8'h00, 3, "rd_unlocked");
    page_en = 1'b0;
    cpu_op(16'h5000, 1'b1, 1'b0, 8'h00, 0, "page_off");
    page_en = 1'b1;
    cpu_op(16'h8000, 1'b0, 1'b1, 8'h11, 0, "above_win");
    cpu_op(16'h3FFF, 1'b0, 1'b1, 8'h22, 0, "below_win");
    check_eq("nonhit_no_ram_wr", n_wr, wr_before);

    // Both strobes together act as a single write.
    cpu_op(16'h7FFF, 1'b1, 1'b1, 8'hC3, 2, "both");
    check_eq("both_one_wr", n_wr, wr_before + 1);
    check_eq("both_dout_kept", cpu_dout, preload(0));
    cpu_op(16'h7FFF, 1'b1, 1'b0, 8'h00, 3, "both_rb");

    // Sprite and DMA held together alternate grants.
    @(posedge clk_sys); #1;
    spr_addr = 14'h0100; dma_addr = 14'h2222;
    log_en = 1'b1; spr_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 40 && grant_log.size() < 8; c++) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    spr_req = 1'b0; dma_req = 1'b0; log_en = 1'b0;
    repeat (5) @(posedge clk_sys);
    check_eq("alt_count_ge8", grant_log.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check_eq($sformatf("alt_seq%0d", i), grant_log[i], (i % 2 == 0) ? 1 : 2);
    check_eq("alt_spr_drained", spr_q.size(), 0);
    check_eq("alt_dma_drained", dma_q.size(), 0);

    // CPU hits every other cycle with sprite held: sprite not starved, CPU resumes.
    spr_addr = 14'h0033;
    cpu_addr = 16'h4010;
    first = 0; cpu_ops = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk_sys); #1;
      cpu_rd = ~cpu_rd;
      if (c == 2) spr_req = 1'b1;
      @(negedge clk_sys);
      if (spr_gnt && first == 0) first = c - 2;
      if (first != 0 && ram_rd && !spr_gnt && !dma_gnt) cpu_ops++;
    end
    @(posedge clk_sys); #1;
    spr_req = 1'b0; cpu_rd = 1'b0;
    repeat (6) @(posedge clk_sys);
    check_eq("spr_latency_ok", (first >= 1) && (first <= 4), 1'b1);
    check_eq("cpu_resumed", cpu_ops > 0, 1'b1);
    check_eq("contend_spr_drained", spr_q.size(), 0);

    // Reset while a DMA read is in flight.
    @(posedge clk_sys); #1;
    dma_addr = 14'h0555; dma_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk_sys);
      got = dma_gnt;
    end
    check_eq("dma_gnt_seen", got, 1'b1);
    rv_before = n_dma_rv;
    #1 apply_reset("dma_rst");
    repeat (5) @(posedge clk_sys);
    check_eq("no_dma_rvalid_after_rst", n_dma_rv, rv_before);

    // Round-robin pointer returns to sprite after reset.
    @(posedge clk_sys); #1;
    spr_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk_sys);
      got = spr_gnt;
    end
    @(posedge clk_sys); #1;
    spr_req = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    apply_reset("rr_rst");
    @(posedge clk_sys); #1;
    spr_req = 1'b1; dma_req = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_eq("rr_after_reset", {spr_gnt, dma_gnt}, 2'b10);
    @(posedge clk_sys); #1;
    spr_req = 1'b0; dma_req = 1'b0;
    repeat (5) @(posedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/asic_ram_arbiter.md
Name: asic_ram_arbiter

Overview:
Shares the single-port 16 KB ASIC register/sprite RAM (14-bit address, 1-cycle read latency) between three requesters: the CPU window at 0x4000-0x7FFF, the sprite pixel fetcher and the 3-channel sound DMA list reader. It sits between those requesters and the ASIC RAM port. CPU access is gated by the unlock status (asic_valid) and by the page-in enable. It issues at most one RAM operation per clk_sys cycle. CPU is stalled via cpu_wait while its access is pending.

Parameters:
ADDR_W, 14, ASIC RAM address width
MAX_WAIT, 4, cycles a granted-eligible sprite/DMA request may be held off by CPU before it is forced ahead

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
asic_valid  in  1  ASIC unlocked; CPU window accesses ignored when 0
page_en  in  1  ASIC page mapped at 0x4000-0x7FFF
cpu_addr  in  16  CPU address
cpu_rd  in  1  CPU read strobe (level)
cpu_wr  in  1  CPU write strobe (level)
cpu_din  in  8  CPU write data
cpu_dout  out  8  registered CPU read data
cpu_wait  out  1  CPU stall while window access pending
spr_req  in  1  sprite fetch request (held until spr_gnt)
spr_addr  in  ADDR_W  sprite fetch address
spr_gnt  out  1  one-cycle grant pulse
spr_rvalid  out  1  one-cycle read-data-valid pulse
dma_req  in  1  DMA list read request (held until dma_gnt)
dma_addr  in  ADDR_W  DMA read address
dma_gnt  out  1  one-cycle grant pulse
dma_rvalid  out  1  one-cycle read-data-valid pulse
rdata  out  8  shared read data, qualified by *_rvalid or CPU completion
ram_addr  out  ADDR_W  RAM address
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe
ram_din  out  8  RAM write data
ram_q  in  8  RAM read data, valid cycle after ram_rd

Behaviour:
- Reset (async, reset_n=0): all outputs 0; cpu_pend, wait counters, rr pointer (=sprite next) cleared; in-flight reads discarded, no rvalid after release.
- CPU hit = (cpu_rd|cpu_wr) rising edge, cpu_addr in [0x4000,0x7FFF], asic_valid=1, page_en=1. On hit: cpu_pend<=1, latch addr[13:0], din, is_write (cpu_wr wins if both strobes high). Non-hits: no RAM op, cpu_wait stays 0.
- cpu_wait = cpu_pend | CPU read in flight; combinational from registers, asserted from cycle after hit until completion cycle inclusive.
- Arbitration each cycle among cpu_pend, spr_req, dma_req (grant of previous cycle's requester excluded the cycle its gnt is high):
  - Any of spr/dma whose wait counter == MAX_WAIT wins over CPU; both saturated -> rr pointer decides.
  - Otherwise CPU first; then sprite/DMA by round-robin; rr pointer flips to the other after each sprite/DMA grant.
  - Wait counter per requester: increments (saturating at MAX_WAIT) each cycle req=1 and not granted; cleared on grant or req=0.
- Grant cycle N+1 for decision in cycle N: registered ram_addr/ram_rd/ram_wr/ram_din driven, matching *_gnt pulse (CPU has no gnt; cpu_pend clears).
- Reads: ram_q sampled N+2 -> rdata and *_rvalid pulse in N+2; CPU read loads cpu_dout in N+2, cpu_wait drops in N+3. CPU write: cpu_wait drops N+2.
- Requester keeping req high after gnt = new request (back-to-back permitted, one op/cycle max).
- asic_valid or page_en falling while cpu_pend: already-accepted access still completes.
- Locked CPU writes never reach RAM; ram_wr only ever from CPU.

Decomposition:
- Shared package asic_pkg: enum asic_req_t {REQ_NONE, REQ_CPU, REQ_SPR, REQ_DMA}; localparams ASIC_WIN_LO=16'h4000, ASIC_WIN_HI=16'h7FFF.
- Sub-module asic_rr_pick: 2-way round-robin picker with saturating wait counters and MAX_WAIT override; arbiter top holds CPU capture, RAM pipeline, data return.

Test Plan:
- Unlocked, page_en=1, CPU write 0x4123=0x5A then read -> ram_wr with addr 0x0123 din 0x5A; read returns cpu_dout=0x5A, cpu_wait high exactly 2 cycles (write) / 3 cycles (read).
- asic_valid=0, CPU write 0x4000 -> no ram_wr, cpu_wait stays 0; later read from same address after unlock returns previous contents.
- spr_req and dma_req held continuously, no CPU -> grants alternate SPR,DMA,SPR,...; each rvalid 1 cycle after its gnt with rdata = RAM preload.
- CPU hits every other cycle with spr_req held -> sprite granted no later than MAX_WAIT=4 cycles after request, then CPU resumes.
- reset_n pulsed low while DMA read in flight -> all outputs 0 immediately, no dma_rvalid after release, rr pointer back to sprite.
- cpu_rd and cpu_wr both rise at 0x7FFF -> treated as write, single ram_wr, no read data returned.
